// File: rtl/ecmac_pkg.sv
// Shared types and helpers for the error-compensation MAC processing element.
package ecmac_pkg;

   typedef enum logic [0:0] {
      ST_NORMAL   = 1'b0,
      ST_DEGRADED = 1'b1
   } ecmac_state_t;

   function automatic int prod_w(input int w);
      return 2 * w;
   endfunction

endpackage

// File: rtl/ecmac_pe_if.sv
// Operand, partial-sum and monitor signal bundle between a PE and its neighbours/controller.
interface ecmac_pe_if
   import ecmac_pkg::*;
#(
   parameter int W_WIDTH    = 8,
   parameter int PSUM_WIDTH = 24,
   parameter int ERR_CNT_W  = 8
);
   logic                          valid_in;
   logic [W_WIDTH-1:0]            weight;
   logic [W_WIDTH-1:0]            activation;
   logic [PSUM_WIDTH-1:0]         partial_sum_in;
   logic [prod_w(W_WIDTH)-1:0]    error_product_in;
   logic                          timing_err_in;
   logic                          clear_degrade;
   logic                          valid_out;
   logic [W_WIDTH-1:0]            next_activation;
   logic [PSUM_WIDTH-1:0]         partial_sum_out;
   logic [prod_w(W_WIDTH)-1:0]    error_product_out;
   logic                          error_out;
   logic                          degrade_out;
   logic [ERR_CNT_W-1:0]          err_count;

   modport master (
      output valid_in, weight, activation, partial_sum_in, error_product_in,
             timing_err_in, clear_degrade,
      input  valid_out, next_activation, partial_sum_out, error_product_out,
             error_out, degrade_out, err_count
   );

   modport slave (
      input  valid_in, weight, activation, partial_sum_in, error_product_in,
             timing_err_in, clear_degrade,
      output valid_out, next_activation, partial_sum_out, error_product_out,
             error_out, degrade_out, err_count
   );
endinterface

// File: rtl/ecmac_err_monitor.sv
// Consecutive/total timing-error counters and the NORMAL/DEGRADED voltage-request FSM.
module ecmac_err_monitor
   import ecmac_pkg::*;
#(
   parameter int ERR_LIMIT = 4,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 err_pulse,
   input  logic                 clean_pulse,
   input  logic                 clear_degrade,
   output logic                 degrade_out,
   output logic [ERR_CNT_W-1:0] err_count
);
   ecmac_state_t         state_q, state_d;
   logic [ERR_CNT_W-1:0] cons_q, cons_d;
   logic [ERR_CNT_W-1:0] tot_q, tot_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_NORMAL;
         cons_q  <= '0;
         tot_q   <= '0;
      end else begin
         state_q <= state_d;
         cons_q  <= cons_d;
         tot_q   <= tot_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cons_d  = cons_q;
      tot_d   = tot_q;

      if (err_pulse) begin
         tot_d  = (tot_q == '1)  ? tot_q  : tot_q + 1'b1;
         cons_d = (cons_q == '1) ? cons_q : cons_q + 1'b1;
      end else if (clean_pulse) begin
         cons_d = '0;
      end

      // clear wins over a simultaneous flagged cycle; the total still counts it
      if (clear_degrade) begin
         cons_d = '0;
      end

      case (state_q)
         ST_NORMAL:   if (!clear_degrade && cons_d >= ERR_CNT_W'(ERR_LIMIT)) state_d = ST_DEGRADED;
         ST_DEGRADED: if (clear_degrade) state_d = ST_NORMAL;
         default:     state_d = ST_NORMAL;
      endcase
   end

   assign degrade_out = (state_q == ST_DEGRADED);
   assign err_count   = tot_q;
endmodule

// File: rtl/ecmac_pe.sv
// Error-compensation MAC PE: flagged cycles defer their product to the next PE.
// Optional build macro ECMAC_SATURATE_EN makes partial-sum additions saturate instead of wrap.
module ecmac_pe
   import ecmac_pkg::*;
#(
   parameter int W_WIDTH    = 8,
   parameter int PSUM_WIDTH = 24,
   parameter int ERR_LIMIT  = 4,
   parameter int ERR_CNT_W  = 8
) (
   input logic        clk,
   input logic        rst_n,
   ecmac_pe_if.slave  bus
);
   localparam int P_W = prod_w(W_WIDTH);

   function automatic logic [PSUM_WIDTH-1:0] psum_add(input logic [PSUM_WIDTH-1:0] a,
                                                      input logic [PSUM_WIDTH-1:0] b);
      logic [PSUM_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
`ifdef ECMAC_SATURATE_EN
      return s[PSUM_WIDTH] ? {PSUM_WIDTH{1'b1}} : s[PSUM_WIDTH-1:0];
`else
      return s[PSUM_WIDTH-1:0];
`endif
   endfunction

   logic [P_W-1:0]        prod_p0;
   logic [PSUM_WIDTH-1:0] comp_p0;
   logic [PSUM_WIDTH-1:0] psum_p0;
   logic                  flag_p0;

   logic                  vld_p1;
   logic                  err_p1;
   logic [W_WIDTH-1:0]    act_p1;
   logic [PSUM_WIDTH-1:0] psum_p1;
   logic [P_W-1:0]        eprod_p1;

   // stage p0: product and compensated partial sum
   assign flag_p0 = bus.valid_in & bus.timing_err_in;
   assign prod_p0 = bus.weight * bus.activation;
   assign comp_p0 = psum_add(bus.partial_sum_in,
                             {{(PSUM_WIDTH-P_W){1'b0}}, bus.error_product_in});
   assign psum_p0 = bus.timing_err_in ? comp_p0
                                      : psum_add(comp_p0, {{(PSUM_WIDTH-P_W){1'b0}}, prod_p0});

   // stage p1: registered outputs; idle cycles hold the data path
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         err_p1   <= 1'b0;
         act_p1   <= '0;
         psum_p1  <= '0;
         eprod_p1 <= '0;
      end else begin
         vld_p1 <= bus.valid_in;
         err_p1 <= flag_p0;
         if (bus.valid_in) begin
            act_p1   <= bus.activation;
            psum_p1  <= psum_p0;
            eprod_p1 <= bus.timing_err_in ? prod_p0 : '0;
         end
      end
   end

   ecmac_err_monitor #(
      .ERR_LIMIT (ERR_LIMIT),
      .ERR_CNT_W (ERR_CNT_W)
   ) u_mon (
      .clk           (clk),
      .rst_n         (rst_n),
      .err_pulse     (flag_p0),
      .clean_pulse   (bus.valid_in & ~bus.timing_err_in),
      .clear_degrade (bus.clear_degrade),
      .degrade_out   (bus.degrade_out),
      .err_count     (bus.err_count)
   );

   assign bus.valid_out         = vld_p1;
   assign bus.error_out         = err_p1;
   assign bus.next_activation   = act_p1;
   assign bus.partial_sum_out   = psum_p1;
   assign bus.error_product_out = eprod_p1;
endmodule

// File: tb/tb_ecmac_pe.sv
// Scoreboard bench for ecmac_pe: directed plan cases plus random traffic against an arithmetic model.
module tb_ecmac_pe;
   localparam int W_WIDTH    = 8;
   localparam int PSUM_WIDTH = 24;
   localparam int ERR_LIMIT  = 4;
   localparam int ERR_CNT_W  = 8;
   localparam longint PSUM_MAX = (longint'(1) << PSUM_WIDTH) - 1;
   localparam longint CNT_MAX  = (longint'(1) << ERR_CNT_W) - 1;

   typedef struct {
      logic [63:0] vout, nact, psum, eprod, eout, deg, cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb_q[$];

   longint m_psum, m_eprod, m_nact, m_cons, m_cnt;
   bit     m_vout, m_eout, m_deg;

   always #5 clk = ~clk;

   ecmac_pe_if #(.W_WIDTH(W_WIDTH), .PSUM_WIDTH(PSUM_WIDTH), .ERR_CNT_W(ERR_CNT_W)) bus ();

   ecmac_pe #(
      .W_WIDTH(W_WIDTH), .PSUM_WIDTH(PSUM_WIDTH), .ERR_LIMIT(ERR_LIMIT), .ERR_CNT_W(ERR_CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference behaviour at the level of the arithmetic rules, one transaction per edge
   task automatic model_step(input bit rn, input bit v, input bit te, input longint w,
                             input longint a, input longint ps, input longint ep, input bit clr);
      longint sum;
      exp_t   e;
      if (!rn) begin
         m_psum = 0; m_eprod = 0; m_nact = 0; m_cons = 0; m_cnt = 0;
         m_vout = 0; m_eout = 0; m_deg = 0;
      end else begin
         m_vout = v;
         m_eout = v && te;
         if (v) begin
            sum = ps + ep + (te ? 0 : w * a);
`ifdef ECMAC_SATURATE_EN
            m_psum = (sum > PSUM_MAX) ? PSUM_MAX : sum;
`else
            m_psum = sum % (PSUM_MAX + 1);
`endif
            m_eprod = te ? w * a : 0;
            m_nact  = a;
            if (te) begin
               if (m_cnt < CNT_MAX) m_cnt++;
               if (m_cons < CNT_MAX) m_cons++;
            end else begin
               m_cons = 0;
            end
         end
         if (clr) begin
            m_cons = 0;
            m_deg  = 0;
         end else if (v && te && m_cons >= ERR_LIMIT) begin
            m_deg = 1;
         end
      end
      e.vout = 64'(m_vout); e.nact = 64'(m_nact); e.psum = 64'(m_psum); e.eprod = 64'(m_eprod);
      e.eout = 64'(m_eout); e.deg = 64'(m_deg); e.cnt = 64'(m_cnt);
      sb_q.push_back(e);
   endtask

   task automatic step(input bit rn, input bit v, input bit te, input longint w, input longint a,
                       input longint ps, input longint ep, input bit clr);
      rst_n                = rn;
      bus.valid_in         = v;
      bus.timing_err_in    = te;
      bus.weight           = W_WIDTH'(w);
      bus.activation       = W_WIDTH'(a);
      bus.partial_sum_in   = PSUM_WIDTH'(ps);
      bus.error_product_in = (2*W_WIDTH)'(ep);
      bus.clear_degrade    = clr;
      @(posedge clk);
      model_step(rn, v, te, w, a, ps, ep, clr);
      #1;
   endtask

   task automatic flagged(input int n);
      for (int i = 0; i < n; i++) step(1, 1, 1, 3 + i, 5, 'h100, 0, 0);
   endtask

   // Monitor: one record per clock, compared on the falling edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("valid_out",         64'(bus.valid_out),         e.vout);
            chk("next_activation",   64'(bus.next_activation),   e.nact);
            chk("partial_sum_out",   64'(bus.partial_sum_out),   e.psum);
            chk("error_product_out", 64'(bus.error_product_out), e.eprod);
            chk("error_out",         64'(bus.error_out),         e.eout);
            chk("degrade_out",       64'(bus.degrade_out),       e.deg);
            chk("err_count",         64'(bus.err_count),         e.cnt);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int budget;
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 7, 7, 'h55, 'h3, 0);
      // plain MAC, deferral, compensation, wrap/saturate
      step(1, 1, 0, 'h10, 'h02, 'h004000, 0, 0);
      step(1, 1, 1, 'h10, 'h02, 'h008000, 0, 0);
      step(1, 1, 0, 'h20, 'h03, 'h001000, 'h0012, 0);
      step(1, 1, 0, 'h10, 'h02, 'hFFFFF0, 0, 0);
      step(1, 1, 0, 'hFF, 'hFF, 'hFFFFFF, 'hFFFF, 0);
      step(1, 0, 1, 'h44, 'h55, 'h123456, 'h77, 0);
      // three flagged then a clean cycle: no degrade
      flagged(3);
      step(1, 1, 0, 1, 1, 0, 0, 0);
      // flagged run broken by an idle cycle still reaches the limit
      flagged(2);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      flagged(2);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1);
      // clear coinciding with the 4th flagged cycle
      flagged(3);
      step(1, 1, 1, 9, 9, 'h10, 0, 1);
      flagged(4);
      flagged(2);
      // reset in the middle of flagged traffic
      step(0, 1, 1, 'h10, 'h02, 'h000100, 'h0004, 0);
      step(1, 1, 0, 'h10, 'h02, 'h004000, 0, 0);
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 1) == 1), $urandom_range(0, 255), $urandom_range(0, 255),
              ($urandom_range(0, 3) == 0) ? PSUM_MAX - $urandom_range(0, 2000)
                                          : longint'($urandom_range(0, 32'hFFFFFF)),
              $urandom_range(0, 16'hFFFF), ($urandom_range(0, 19) == 0));
      end
      step(1, 0, 0, 0, 0, 0, 0, 0);
      budget = 20;
      while (sb_q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d records left, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
